// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants for the regfile write-port arbiter
package regfile_write_arbiter_pkg;

  localparam int ARF_ADDR_WIDTH = 5;
  localparam int ARF_DATA_WIDTH = 32;
  localparam int GRANT_ID_W     = 3;

  localparam int REQ_CPU = 0;

  // Registers the regfile reserves for peripheral writers
  localparam int PERIPH_REG_FIRST = 24;
  localparam int PERIPH_REG_LAST  = 29;

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
// rtl/regfile_write_arbiter_rr_priority_pick.sv - rotate-and-priority-encode over peripheral requesters
module rr_priority_pick
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]            valid,
  input  logic [GRANT_ID_W-1:0]   ptr,
  output logic [N-1:0]            onehot,
  output logic                    found
);

  // Bit j of valid/onehot is requester j+1; ptr is a requester index in 1..N
  always_comb begin
    int start;
    int idx;
    onehot = '0;
    found  = 1'b0;
    start  = int'(ptr) - 1;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (start + i) % N;
      if (!found && valid[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port: CPU priority, peripherals round-robin with anti-starvation
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = ARF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = ARF_DATA_WIDTH,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clock,
  input  logic                          ctrl_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]         data_writeReg,
  output logic [GRANT_ID_W-1:0]         grant_id,
  output logic                          starve_active
);

  localparam int NP = NUM_REQ - 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [NP-1:0]          periph_valid;
  logic [NP-1:0]          pick_onehot;
  logic                   pick_found;
  logic                   any_periph;
  logic                   starve_hit;
  logic [NUM_REQ-1:0]     grant;
  logic                   periph_win;
  logic                   any_grant;
  logic [GRANT_ID_W-1:0]  sel_idx;
  logic [ADDR_WIDTH-1:0]  sel_reg;
  logic [DATA_WIDTH-1:0]  sel_data;

  logic [GRANT_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          starve_cnt_q, starve_cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [GRANT_ID_W-1:0]  grant_id_q, grant_id_d;
  logic                   starve_active_q, starve_active_d;

  assign periph_valid = req_valid[NUM_REQ-1:1];
  assign any_periph   = |periph_valid;
  assign starve_hit   = (starve_cnt_q == CW'(STARVE_LIMIT)) && any_periph;

  rr_priority_pick #(.N(NP)) u_pick (
    .valid  (periph_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .found  (pick_found)
  );

  always_comb begin
    grant      = '0;
    periph_win = 1'b0;
    if (!ctrl_reset) begin
      if (starve_hit) begin
        grant[NUM_REQ-1:1] = pick_onehot;
        periph_win         = 1'b1;
      end else if (req_valid[REQ_CPU]) begin
        grant[REQ_CPU] = 1'b1;
      end else if (pick_found) begin
        grant[NUM_REQ-1:1] = pick_onehot;
        periph_win         = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    sel_idx  = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx  = GRANT_ID_W'(i);
        sel_reg  = req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    starve_cnt_d    = starve_cnt_q;
    we_d            = any_grant && (sel_reg != '0);
    wreg_d          = wreg_q;
    wdata_d         = wdata_q;
    grant_id_d      = grant_id_q;
    starve_active_d = starve_hit;

    if (periph_win) begin
      rr_ptr_d = (sel_idx == GRANT_ID_W'(NUM_REQ - 1)) ? GRANT_ID_W'(1) : sel_idx + GRANT_ID_W'(1);
    end

    // The counter only tracks CPU wins that actually blocked a waiting peripheral
    if (periph_win || !any_periph) begin
      starve_cnt_d = '0;
    end else if (grant[REQ_CPU] && (starve_cnt_q != CW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    if (any_grant) begin
      wreg_d     = sel_reg;
      wdata_d    = sel_data;
      grant_id_d = sel_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      rr_ptr_q        <= GRANT_ID_W'(1);
      starve_cnt_q    <= '0;
      we_q            <= 1'b0;
      wreg_q          <= '0;
      wdata_q         <= '0;
      grant_id_q      <= '0;
      starve_active_q <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      starve_cnt_q    <= starve_cnt_d;
      we_q            <= we_d;
      wreg_q          <= wreg_d;
      wdata_q         <= wdata_d;
      grant_id_q      <= grant_id_d;
      starve_active_q <= starve_active_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign grant_id         = grant_id_q;
  assign starve_active    = starve_active_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clock = 1'b0;
  logic             ctrl_reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_reg;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             ctrl_writeEnable;
  logic [AW-1:0]    ctrl_writeReg;
  logic [DW-1:0]    data_writeReg;
  logic [2:0]       grant_id;
  logic             starve_active;

  logic [DW-1:0]    port_log [0:31];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .grant_id         (grant_id),
    .starve_active    (starve_active)
  );

  // Raw log of every write the port presents, register 0 included
  initial begin
    for (int i = 0; i < 32; i++) port_log[i] = '0;
  end
  always @(posedge clock) begin
    if (ctrl_writeEnable) port_log[ctrl_writeReg] <= data_writeReg;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_reg[i*AW +: AW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  int exp_id;

  initial begin
    ctrl_reset = 1'b1;
    req_valid  = '0;
    req_reg    = '0;
    req_data   = '0;
    set_req(0, 5'd3,  32'h0000_0011);
    set_req(1, 5'd24, 32'hA000_0001);
    set_req(2, 5'd25, 32'hA000_0002);
    set_req(3, 5'd27, 32'hA000_0003);

    tick();
    check("rst_ready", 64'(req_ready), 64'd0);
    tick();
    check("rst_we", 64'(ctrl_writeEnable), 64'd0);
    check("rst_reg", 64'(ctrl_writeReg), 64'd0);
    check("rst_data", 64'(data_writeReg), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    check("rst_starve", 64'(starve_active), 64'd0);
    check("rst_ready2", 64'(req_ready), 64'd0);

    ctrl_reset = 1'b0;
    #1;
    check("rel_ready", 64'(req_ready), 64'b0001);
    tick();
    check("cpu_we", 64'(ctrl_writeEnable), 64'd1);
    check("cpu_gid", 64'(grant_id), 64'd0);
    check("cpu_reg", 64'(ctrl_writeReg), 64'd3);
    check("cpu_data", 64'(data_writeReg), 64'h11);

    req_valid = '0;
    #1;
    check("idle_ready", 64'(req_ready), 64'd0);
    tick();
    check("idle_we", 64'(ctrl_writeEnable), 64'd0);
    check("idle_gid", 64'(grant_id), 64'd0);
    check("idle_reg", 64'(ctrl_writeReg), 64'd3);

    set_req(2, 5'd25, 32'hDEAD_BEEF);
    #1;
    check("r2_ready", 64'(req_ready), 64'b0100);
    tick();
    check("r2_we", 64'(ctrl_writeEnable), 64'd1);
    check("r2_reg", 64'(ctrl_writeReg), 64'd25);
    check("r2_data", 64'(data_writeReg), 64'hDEAD_BEEF);
    check("r2_gid", 64'(grant_id), 64'd2);

    // Pointer now sits at 3, so the rotation starts there
    req_valid = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      exp_id = (k % 3 == 0) ? 3 : (k % 3 == 1) ? 1 : 2;
      #1;
      check("rr_ready", 64'(req_ready), 64'(1) << exp_id);
      tick();
      check("rr_we", 64'(ctrl_writeEnable), 64'd1);
      check("rr_gid", 64'(grant_id), 64'(exp_id));
    end

    req_valid = '0;
    tick();
    check("hold_we", 64'(ctrl_writeEnable), 64'd0);
    check("hold_gid", 64'(grant_id), 64'd2);
    check("hold_reg", 64'(ctrl_writeReg), 64'd25);
    check("hold_data", 64'(data_writeReg), 64'hDEAD_BEEF);

    // Contention: 8 CPU wins, forced peripheral (3 from pointer), 8 CPU, forced 1
    req_valid = 4'b1111;
    for (int i = 0; i < 18; i++) begin
      exp_id = (i == 8) ? 3 : (i == 17) ? 1 : 0;
      #1;
      check("st_ready", 64'(req_ready), 64'(1) << exp_id);
      tick();
      check("st_gid", 64'(grant_id), 64'(exp_id));
      check("st_we", 64'(ctrl_writeEnable), 64'd1);
      check("st_flag", 64'(starve_active), (i == 8 || i == 17) ? 64'd1 : 64'd0);
    end

    req_valid = '0;
    set_req(1, 5'd0, 32'd5);
    #1;
    check("r0_ready", 64'(req_ready), 64'b0010);
    tick();
    check("r0_we", 64'(ctrl_writeEnable), 64'd0);
    check("r0_gid", 64'(grant_id), 64'd1);
    check("r0_reg", 64'(ctrl_writeReg), 64'd0);
    check("r0_data", 64'(data_writeReg), 64'd5);
    req_valid = '0;
    tick();
    check("r0_read", 64'(port_log[0]), 64'd0);

    set_req(3, 5'd27, 32'hCAFE_F00D);
    #1;
    check("mr_ready", 64'(req_ready), 64'b1000);
    ctrl_reset = 1'b1;
    req_valid  = '0;
    #1;
    check("mr_ready_rst", 64'(req_ready), 64'd0);
    tick();
    check("mr_we", 64'(ctrl_writeEnable), 64'd0);
    tick();
    check("mr_target", 64'(port_log[27]), 64'hA000_0003);
    check("mr_gid", 64'(grant_id), 64'd0);
    ctrl_reset = 1'b0;
    tick();
    check("mr_post_we", 64'(ctrl_writeEnable), 64'd0);
    check("mr_post_ready", 64'(req_ready), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
